hazard_ctrl: RTL and testbench

Central pipeline sequencer for the five-stage core (fetch, decode, execute, memory, writeback).
- Generates per-stage stall/flush/ce controls from three event sources: load-use hazards, branch/jump redirects, and memory-stage bus waits.
- Redirects the fetch PC, including a trap redirect when a memory-bus access times out.
- Sits beside the stage chain, replacing the free-running fetch-stage stall/flush/ce inputs.

---
 rtl/hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: turns load-use hazards, execute-stage redirects and memory bus waits
// into registered per-stage stall/flush/enable controls and fetch PC redirects.
module hazard_ctrl #(
    parameter int                    AWIDTH      = 5,
    parameter int                    PC_WIDTH    = 32,
    parameter int                    MEM_TIMEOUT = 15,
    parameter int                    TO_WIDTH    = 4,
    parameter logic [PC_WIDTH-1:0]   TRAP_PC     = 32'h0000_0004
) (
    input  logic                hc_clk,
    input  logic                hc_rst,
    input  logic [AWIDTH-1:0]   hc_i_ds_rs1_addr,
    input  logic [AWIDTH-1:0]   hc_i_ds_rs2_addr,
    input  logic                hc_i_ds_read_reg,
    input  logic [AWIDTH-1:0]   hc_i_ex_rd_addr,
    input  logic                hc_i_ex_is_load,
    input  logic                hc_i_ex_valid,
    input  logic                hc_i_change_pc,
    input  logic [PC_WIDTH-1:0] hc_i_next_pc,
    input  logic                hc_i_me_cyc,
    input  logic                hc_i_me_ack,
    output logic                hc_o_fi_ce,
    output logic                hc_o_fi_stall,
    output logic                hc_o_ds_stall,
    output logic                hc_o_ex_stall,
    output logic                hc_o_me_stall,
    output logic                hc_o_ds_flush,
    output logic                hc_o_ex_flush,
    output logic                hc_o_pc_load,
    output logic [PC_WIDTH-1:0] hc_o_pc_value,
    output logic                hc_o_mem_err,
    output logic [1:0]          hc_o_state
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_e;

    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(MEM_TIMEOUT);
    localparam logic [TO_WIDTH-1:0] TO_MAX   = '1;

    state_e                state_q, state_d;
    logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
    logic [1:0]            fl_cnt_q, fl_cnt_d;
    logic [PC_WIDTH-1:0]   pc_value_q, pc_value_d;
    logic                  fi_ce_q, fi_ce_d;
    logic                  fi_stall_q, fi_stall_d;
    logic                  ds_stall_q, ds_stall_d;
    logic                  ex_stall_q, ex_stall_d;
    logic                  me_stall_q, me_stall_d;
    logic                  ds_flush_q, ds_flush_d;
    logic                  ex_flush_q, ex_flush_d;
    logic                  pc_load_q, pc_load_d;
    logic                  mem_err_q, mem_err_d;

    logic                  load_use;
    logic                  mem_wait_req;

    // A load in execute whose destination is read by decode needs one bubble; x0 never conflicts.
    assign load_use = hc_i_ex_valid && hc_i_ex_is_load && (hc_i_ex_rd_addr != '0) &&
                      hc_i_ds_read_reg &&
                      ((hc_i_ex_rd_addr == hc_i_ds_rs1_addr) ||
                       (hc_i_ex_rd_addr == hc_i_ds_rs2_addr));

    assign mem_wait_req = hc_i_me_cyc && !hc_i_me_ack;

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        fl_cnt_d   = fl_cnt_q;
        pc_value_d = pc_value_q;
        pc_load_d  = 1'b0;
        mem_err_d  = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_wait_req) begin
                    state_d  = MEM_WAIT;
                    to_cnt_d = TO_WIDTH'(1);
                end else if (hc_i_change_pc) begin
                    state_d    = FLUSH;
                    pc_value_d = hc_i_next_pc;
                    fl_cnt_d   = 2'd2;
                    pc_load_d  = 1'b1;
                end else if (load_use) begin
                    state_d = LOAD_STALL;
                end
            end

            LOAD_STALL: begin
                if (hc_i_change_pc) begin
                    state_d    = FLUSH;
                    pc_value_d = hc_i_next_pc;
                    fl_cnt_d   = 2'd2;
                    pc_load_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end

            // Redirect requests are ignored here; execute is held and re-presents them later.
            MEM_WAIT: begin
                if (hc_i_me_ack) begin
                    state_d  = RUN;
                    to_cnt_d = '0;
                end else if (to_cnt_q >= TO_LIMIT) begin
                    state_d    = FLUSH;
                    to_cnt_d   = '0;
                    pc_value_d = TRAP_PC;
                    fl_cnt_d   = 2'd2;
                    pc_load_d  = 1'b1;
                    mem_err_d  = 1'b1;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            FLUSH: begin
                if (fl_cnt_q <= 2'd1) begin
                    state_d  = RUN;
                    fl_cnt_d = 2'd0;
                end else begin
                    fl_cnt_d = fl_cnt_q - 2'd1;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Output flops are loaded from the upcoming state so every control is a clean register.
    always_comb begin
        fi_ce_d    = 1'b1;
        fi_stall_d = (state_d == LOAD_STALL) || (state_d == MEM_WAIT);
        ds_stall_d = (state_d == LOAD_STALL) || (state_d == MEM_WAIT);
        ex_stall_d = (state_d == MEM_WAIT);
        me_stall_d = (state_d == MEM_WAIT);
        ds_flush_d = (state_d == FLUSH);
        ex_flush_d = (state_d == FLUSH) || (state_d == LOAD_STALL);
    end

    always_ff @(posedge hc_clk) begin
        if (hc_rst) begin
            state_q    <= RUN;
            to_cnt_q   <= '0;
            fl_cnt_q   <= '0;
            pc_value_q <= '0;
            fi_ce_q    <= 1'b0;
            fi_stall_q <= 1'b0;
            ds_stall_q <= 1'b0;
            ex_stall_q <= 1'b0;
            me_stall_q <= 1'b0;
            ds_flush_q <= 1'b0;
            ex_flush_q <= 1'b0;
            pc_load_q  <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            fl_cnt_q   <= fl_cnt_d;
            pc_value_q <= pc_value_d;
            fi_ce_q    <= fi_ce_d;
            fi_stall_q <= fi_stall_d;
            ds_stall_q <= ds_stall_d;
            ex_stall_q <= ex_stall_d;
            me_stall_q <= me_stall_d;
            ds_flush_q <= ds_flush_d;
            ex_flush_q <= ex_flush_d;
            pc_load_q  <= pc_load_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign hc_o_fi_ce    = fi_ce_q;
    assign hc_o_fi_stall = fi_stall_q;
    assign hc_o_ds_stall = ds_stall_q;
    assign hc_o_ex_stall = ex_stall_q;
    assign hc_o_me_stall = me_stall_q;
    assign hc_o_ds_flush = ds_flush_q;
    assign hc_o_ex_flush = ex_flush_q;
    assign hc_o_pc_load  = pc_load_q;
    assign hc_o_pc_value = pc_value_q;
    assign hc_o_mem_err  = mem_err_q;
    assign hc_o_state    = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Vector-table bench for hazard_ctrl: each row drives one cycle of inputs and queues the
// outputs expected after the following rising edge.
module tb_hazard_ctrl;

    typedef struct packed {
        logic        rst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        read_reg;
        logic [4:0]  ex_rd;
        logic        is_load;
        logic        ex_valid;
        logic        change_pc;
        logic [31:0] next_pc;
        logic        me_cyc;
        logic        me_ack;
    } in_t;

    typedef struct packed {
        logic        fi_ce;
        logic        fi_stall;
        logic        ds_stall;
        logic        ex_stall;
        logic        me_stall;
        logic        ds_flush;
        logic        ex_flush;
        logic        pc_load;
        logic [31:0] pc_value;
        logic        mem_err;
        logic [1:0]  state;
    } out_t;

    typedef struct packed {
        in_t  vin;
        out_t vexp;
    } vec_t;

    logic        hc_clk;
    logic        hc_rst;
    logic [4:0]  hc_i_ds_rs1_addr;
    logic [4:0]  hc_i_ds_rs2_addr;
    logic        hc_i_ds_read_reg;
    logic [4:0]  hc_i_ex_rd_addr;
    logic        hc_i_ex_is_load;
    logic        hc_i_ex_valid;
    logic        hc_i_change_pc;
    logic [31:0] hc_i_next_pc;
    logic        hc_i_me_cyc;
    logic        hc_i_me_ack;
    logic        hc_o_fi_ce;
    logic        hc_o_fi_stall;
    logic        hc_o_ds_stall;
    logic        hc_o_ex_stall;
    logic        hc_o_me_stall;
    logic        hc_o_ds_flush;
    logic        hc_o_ex_flush;
    logic        hc_o_pc_load;
    logic [31:0] hc_o_pc_value;
    logic        hc_o_mem_err;
    logic [1:0]  hc_o_state;

    vec_t tbl[$];
    out_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    hazard_ctrl dut (
        .hc_clk           (hc_clk),
        .hc_rst           (hc_rst),
        .hc_i_ds_rs1_addr (hc_i_ds_rs1_addr),
        .hc_i_ds_rs2_addr (hc_i_ds_rs2_addr),
        .hc_i_ds_read_reg (hc_i_ds_read_reg),
        .hc_i_ex_rd_addr  (hc_i_ex_rd_addr),
        .hc_i_ex_is_load  (hc_i_ex_is_load),
        .hc_i_ex_valid    (hc_i_ex_valid),
        .hc_i_change_pc   (hc_i_change_pc),
        .hc_i_next_pc     (hc_i_next_pc),
        .hc_i_me_cyc      (hc_i_me_cyc),
        .hc_i_me_ack      (hc_i_me_ack),
        .hc_o_fi_ce       (hc_o_fi_ce),
        .hc_o_fi_stall    (hc_o_fi_stall),
        .hc_o_ds_stall    (hc_o_ds_stall),
        .hc_o_ex_stall    (hc_o_ex_stall),
        .hc_o_me_stall    (hc_o_me_stall),
        .hc_o_ds_flush    (hc_o_ds_flush),
        .hc_o_ex_flush    (hc_o_ex_flush),
        .hc_o_pc_load     (hc_o_pc_load),
        .hc_o_pc_value    (hc_o_pc_value),
        .hc_o_mem_err     (hc_o_mem_err),
        .hc_o_state       (hc_o_state)
    );

    initial begin
        hc_clk = 1'b0;
        forever #5 hc_clk = ~hc_clk;
    end

    function automatic in_t in_idle();
        in_t t;
        t = '0;
        return t;
    endfunction

    function automatic in_t in_rst();
        in_t t;
        t = '0;
        t.rst = 1'b1;
        return t;
    endfunction

    function automatic in_t in_hz(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic load,
                                  input logic valid, input logic rr);
        in_t t;
        t = '0;
        t.ex_rd    = rd;
        t.rs1      = rs1;
        t.rs2      = rs2;
        t.is_load  = load;
        t.ex_valid = valid;
        t.read_reg = rr;
        return t;
    endfunction

    function automatic in_t in_br(input logic [31:0] pc);
        in_t t;
        t = '0;
        t.change_pc = 1'b1;
        t.next_pc   = pc;
        return t;
    endfunction

    function automatic in_t in_mem(input logic ack);
        in_t t;
        t = '0;
        t.me_cyc = 1'b1;
        t.me_ack = ack;
        return t;
    endfunction

    function automatic out_t o_rst();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t o_run(input logic [31:0] pc);
        out_t o;
        o = '0;
        o.fi_ce    = 1'b1;
        o.pc_value = pc;
        return o;
    endfunction

    function automatic out_t o_ls(input logic [31:0] pc);
        out_t o;
        o = o_run(pc);
        o.fi_stall = 1'b1;
        o.ds_stall = 1'b1;
        o.ex_flush = 1'b1;
        o.state    = 2'd1;
        return o;
    endfunction

    function automatic out_t o_mw(input logic [31:0] pc);
        out_t o;
        o = o_run(pc);
        o.fi_stall = 1'b1;
        o.ds_stall = 1'b1;
        o.ex_stall = 1'b1;
        o.me_stall = 1'b1;
        o.state    = 2'd2;
        return o;
    endfunction

    function automatic out_t o_fl(input logic [31:0] pc, input logic load, input logic err);
        out_t o;
        o = o_run(pc);
        o.ds_flush = 1'b1;
        o.ex_flush = 1'b1;
        o.pc_load  = load;
        o.mem_err  = err;
        o.state    = 2'd3;
        return o;
    endfunction

    task automatic addVec(input in_t i, input out_t o);
        vec_t v;
        v.vin  = i;
        v.vexp = o;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        hc_rst           = v.vin.rst;
        hc_i_ds_rs1_addr = v.vin.rs1;
        hc_i_ds_rs2_addr = v.vin.rs2;
        hc_i_ds_read_reg = v.vin.read_reg;
        hc_i_ex_rd_addr  = v.vin.ex_rd;
        hc_i_ex_is_load  = v.vin.is_load;
        hc_i_ex_valid    = v.vin.ex_valid;
        hc_i_change_pc   = v.vin.change_pc;
        hc_i_next_pc     = v.vin.next_pc;
        hc_i_me_cyc      = v.vin.me_cyc;
        hc_i_me_ack      = v.vin.me_ack;
        exp_q.push_back(v.vexp);
    endtask

    task automatic checkOutput(input int idx);
        out_t act;
        out_t exp;
        act.fi_ce    = hc_o_fi_ce;
        act.fi_stall = hc_o_fi_stall;
        act.ds_stall = hc_o_ds_stall;
        act.ex_stall = hc_o_ex_stall;
        act.me_stall = hc_o_me_stall;
        act.ds_flush = hc_o_ds_flush;
        act.ex_flush = hc_o_ex_flush;
        act.pc_load  = hc_o_pc_load;
        act.pc_value = hc_o_pc_value;
        act.mem_err  = hc_o_mem_err;
        act.state    = hc_o_state;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL vec%0d scoreboard empty, got %h", idx, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                tests_failed++;
                $display("[TB] FAIL vec%0d outputs got %h expected %h (state got %0d expected %0d)",
                         idx, act, exp, act.state, exp.state);
            end
        end
    endtask

    initial begin
        in_t t;

        // Reset held three cycles, then basic run.
        for (int k = 0; k < 3; k++) addVec(in_rst(), o_rst());
        addVec(in_idle(), o_run(32'h0));

        // Load-use on rs2; hazard inputs held during the stall must not extend it.
        addVec(in_hz(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1), o_ls(32'h0));
        addVec(in_hz(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1), o_run(32'h0));
        addVec(in_idle(), o_run(32'h0));
        addVec(in_hz(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1), o_run(32'h0));
        addVec(in_hz(5'd7, 5'd7, 5'd2, 1'b0, 1'b1, 1'b1), o_run(32'h0));
        addVec(in_hz(5'd7, 5'd7, 5'd2, 1'b1, 1'b0, 1'b1), o_run(32'h0));
        addVec(in_hz(5'd7, 5'd7, 5'd2, 1'b1, 1'b1, 1'b0), o_run(32'h0));
        addVec(in_hz(5'd9, 5'd9, 5'd2, 1'b1, 1'b1, 1'b1), o_ls(32'h0));

        // Redirect out of LOAD_STALL, then a plain redirect with a second request ignored.
        addVec(in_br(32'h0000_0040), o_fl(32'h0000_0040, 1'b1, 1'b0));
        addVec(in_idle(), o_fl(32'h0000_0040, 1'b0, 1'b0));
        addVec(in_idle(), o_run(32'h0000_0040));
        addVec(in_br(32'h0000_0080), o_fl(32'h0000_0080, 1'b1, 1'b0));
        addVec(in_br(32'h0000_0100), o_fl(32'h0000_0080, 1'b0, 1'b0));
        addVec(in_idle(), o_run(32'h0000_0080));

        // Redirect beats a simultaneous load-use hazard.
        t = in_hz(5'd3, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1);
        t.change_pc = 1'b1;
        t.next_pc   = 32'h0000_00C0;
        addVec(t, o_fl(32'h0000_00C0, 1'b1, 1'b0));
        addVec(in_idle(), o_fl(32'h0000_00C0, 1'b0, 1'b0));
        addVec(in_idle(), o_run(32'h0000_00C0));

        // Same-cycle ack is no wait; then a 3-cycle wait with redirect requests ignored.
        addVec(in_mem(1'b1), o_run(32'h0000_00C0));
        t = in_mem(1'b0);
        t.change_pc = 1'b1;
        t.next_pc   = 32'h0000_0200;
        for (int k = 0; k < 3; k++) addVec(t, o_mw(32'h0000_00C0));
        t.me_ack = 1'b1;
        addVec(t, o_run(32'h0000_00C0));
        addVec(in_idle(), o_run(32'h0000_00C0));

        // Bus timeout: 15 wait cycles, then trap redirect with a one-cycle error pulse.
        for (int k = 0; k < 15; k++) addVec(in_mem(1'b0), o_mw(32'h0000_00C0));
        addVec(in_mem(1'b0), o_fl(32'h0000_0004, 1'b1, 1'b1));
        addVec(in_idle(), o_fl(32'h0000_0004, 1'b0, 1'b0));
        addVec(in_idle(), o_run(32'h0000_0004));

        // Reset during MEM_WAIT.
        addVec(in_mem(1'b0), o_mw(32'h0000_0004));
        addVec(in_mem(1'b0), o_mw(32'h0000_0004));
        addVec(in_rst(), o_rst());
        addVec(in_idle(), o_run(32'h0));

        // Reset during FLUSH.
        addVec(in_br(32'h0000_0300), o_fl(32'h0000_0300, 1'b1, 1'b0));
        addVec(in_rst(), o_rst());
        addVec(in_idle(), o_run(32'h0));

        // Reset on the exact cycle the timeout would fire: no error pulse.
        for (int k = 0; k < 15; k++) addVec(in_mem(1'b0), o_mw(32'h0));
        t = in_mem(1'b0);
        t.rst = 1'b1;
        addVec(t, o_rst());
        addVec(in_idle(), o_run(32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            @(posedge hc_clk);
            #1;
            checkOutput(i);
            @(negedge hc_clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
